// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronises and deglitches the PS/2 lines, deserialises
// 11-bit frames and emits scan-code bytes with parity/framing/timeout error strobes.
module ps2_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte,
  output logic       o_byte_en,
  output logic       o_parity_err,
  output logic       o_frame_err
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FCW-1:0] FILT_MAX = FCW'(FILTER_LEN - 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [3:0] STOP_IDX = 4'd9;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  logic [SYNC_STAGES-1:0] clk_sync_r;
  logic [SYNC_STAGES-1:0] data_sync_r;
  logic                   clk_s;
  logic                   data_s;

  logic [FCW-1:0]         filt_cnt_r;
  logic                   fclk_r;
  logic                   fclk_d_r;
  logic                   fall_s;

  state_t                 state_r;
  state_t                 state_nxt;
  logic [3:0]             bitcnt_r;
  logic [8:0]             shift_r;
  logic [TW-1:0]          tcnt_r;
  logic                   timeout_s;

  logic [7:0]             byte_nxt;
  logic                   byte_en_nxt;
  logic                   parity_err_nxt;
  logic                   frame_err_nxt;

  // Input synchronisers for both asynchronous PS/2 lines
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      clk_sync_r  <= {SYNC_STAGES{1'b1}};
      data_sync_r <= {SYNC_STAGES{1'b1}};
    end else begin
      clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], i_ps2_clk};
      data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], i_ps2_data};
    end
  end

  assign clk_s  = clk_sync_r[SYNC_STAGES-1];
  assign data_s = data_sync_r[SYNC_STAGES-1];

  // Clock deglitch filter: fclk follows clk_s only after FILTER_LEN agreeing samples
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fclk_r     <= 1'b1;
      fclk_d_r   <= 1'b1;
      filt_cnt_r <= {FCW{1'b0}};
    end else begin
      fclk_d_r <= fclk_r;
      if (clk_s != fclk_r) begin
        if (filt_cnt_r == FILT_MAX) begin
          fclk_r     <= clk_s;
          filt_cnt_r <= {FCW{1'b0}};
        end else begin
          filt_cnt_r <= filt_cnt_r + FCW'(1);
        end
      end else begin
        filt_cnt_r <= {FCW{1'b0}};
      end
    end
  end

  assign fall_s    = fclk_d_r & ~fclk_r;
  assign timeout_s = (state_r == RECV) && (tcnt_r == TMO_MAX);

  // FSM state register
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // FSM next-state logic; a fall takes priority over an expiring timeout
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (fall_s && !data_s) begin
          state_nxt = RECV;
        end else begin
          state_nxt = IDLE;
        end
      end
      RECV: begin
        if (fall_s) begin
          if (bitcnt_r == STOP_IDX) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = RECV;
          end
        end else if (timeout_s) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = RECV;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit counter, shift register and inter-edge timeout counter
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bitcnt_r <= 4'd0;
      shift_r  <= 9'd0;
      tcnt_r   <= {TW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          bitcnt_r <= 4'd0;
          tcnt_r   <= {TW{1'b0}};
        end
        RECV: begin
          if (fall_s) begin
            tcnt_r <= {TW{1'b0}};
            if (bitcnt_r == STOP_IDX) begin
              bitcnt_r <= 4'd0;
            end else begin
              bitcnt_r <= bitcnt_r + 4'd1;
              shift_r  <= {data_s, shift_r[8:1]};
            end
          end else if (timeout_s) begin
            bitcnt_r <= 4'd0;
            tcnt_r   <= {TW{1'b0}};
          end else begin
            tcnt_r <= tcnt_r + TW'(1);
          end
        end
        default: begin
          bitcnt_r <= 4'd0;
          tcnt_r   <= {TW{1'b0}};
        end
      endcase
    end
  end

  // FSM output logic: frame evaluation on the stop-bit fall, or timeout abort
  always_comb begin
    byte_nxt       = o_byte;
    byte_en_nxt    = 1'b0;
    parity_err_nxt = 1'b0;
    frame_err_nxt  = 1'b0;
    case (state_r)
      RECV: begin
        if (fall_s && (bitcnt_r == STOP_IDX)) begin
          if (!data_s) begin
            frame_err_nxt = 1'b1;
          end else if (odd_parity_ok(shift_r[7:0], shift_r[8])) begin
            byte_nxt    = shift_r[7:0];
            byte_en_nxt = 1'b1;
          end else begin
            parity_err_nxt = 1'b1;
          end
        end else if (!fall_s && timeout_s) begin
          frame_err_nxt = 1'b1;
        end else begin
          byte_en_nxt = 1'b0;
        end
      end
      IDLE:    byte_en_nxt = 1'b0;
      default: byte_en_nxt = 1'b0;
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_byte       <= 8'h00;
      o_byte_en    <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_byte       <= byte_nxt;
      o_byte_en    <= byte_en_nxt;
      o_parity_err <= parity_err_nxt;
      o_frame_err  <= frame_err_nxt;
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: a scoreboard queue holds the expected strobe events and
// a negedge monitor pops and checks them, including latency and timeout windows.
module tb_ps2_rx;

  localparam int HALF   = 20;
  localparam int CLK_NS = 20;

  localparam logic [2:0] EV_EN = 3'b100;
  localparam logic [2:0] EV_PE = 3'b010;
  localparam logic [2:0] EV_FE = 3'b001;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] val;
    time        lo_ns;
    time        hi_ns;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] o_byte;
  logic       o_byte_en;
  logic       o_parity_err;
  logic       o_frame_err;

  int   n_tests;
  int   n_fail;
  exp_t sb[$];
  exp_t mon_e;
  logic [7:0] model_byte;
  time  last_fall_t;

  ps2_rx dut (
    .clk          (clk),
    .i_rst_n      (rst_n),
    .i_ps2_clk    (ps2_clk),
    .i_ps2_data   (ps2_data),
    .o_byte       (o_byte),
    .o_byte_en    (o_byte_en),
    .o_parity_err (o_parity_err),
    .o_frame_err  (o_frame_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input logic [2:0] kind, input logic [7:0] val,
                           input time lo_ns, input time hi_ns);
    exp_t e;
    if (kind == EV_EN) model_byte = val;
    e.kind  = kind;
    e.val   = model_byte;
    e.lo_ns = lo_ns;
    e.hi_ns = hi_ns;
    sb.push_back(e);
  endtask

  task automatic ps2_bit(input logic b, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      tick(HALF / 2);
      ps2_clk = 1'b0;
      tick(2);
      ps2_clk = 1'b1;
      tick(HALF - HALF / 2 - 2);
    end else begin
      tick(HALF);
    end
    ps2_clk = 1'b0;
    last_fall_t = $time;
    tick(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_flip, input logic stop,
                            input int nbits, input int glitch_bit);
    logic [10:0] bits;
    bits = {stop, (~^d) ^ par_flip, d, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(bits[i], i == glitch_bit);
    ps2_data = 1'b1;
    tick(HALF);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 2000 && sb.size() != 0; i++) tick(1);
    n_tests++;
    assert (sb.size() == 0)
    else begin
      n_fail++;
      $error("FAIL %s: pending events observed=%0d expected=0", tag, sb.size());
    end
  endtask

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_n && (o_byte_en || o_parity_err || o_frame_err)) begin
      n_tests++;
      assert (sb.size() != 0)
      else begin
        n_fail++;
        $error("FAIL sb_unexpected: observed strobes=%b byte=%h expected=none",
               {o_byte_en, o_parity_err, o_frame_err}, o_byte);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        n_tests++;
        assert ({o_byte_en, o_parity_err, o_frame_err} === mon_e.kind)
        else begin
          n_fail++;
          $error("FAIL sb_kind: observed=%b expected=%b",
                 {o_byte_en, o_parity_err, o_frame_err}, mon_e.kind);
        end
        n_tests++;
        assert (o_byte === mon_e.val)
        else begin
          n_fail++;
          $error("FAIL sb_byte: observed=%h expected=%h", o_byte, mon_e.val);
        end
        n_tests++;
        assert (($time - last_fall_t) >= mon_e.lo_ns && ($time - last_fall_t) <= mon_e.hi_ns)
        else begin
          n_fail++;
          $error("FAIL sb_latency: observed=%0t expected=%0t..%0t",
                 $time - last_fall_t, mon_e.lo_ns, mon_e.hi_ns);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    model_byte  = 8'h00;
    last_fall_t = 0;
    rst_n       = 1'b0;
    ps2_clk     = 1'b1;
    ps2_data    = 1'b1;
    tick(5);
    check_val("rst_byte", o_byte, 8'h00);
    check_val("rst_en", {7'd0, o_byte_en}, 8'h00);
    check_val("rst_perr", {7'd0, o_parity_err}, 8'h00);
    check_val("rst_ferr", {7'd0, o_frame_err}, 8'h00);
    rst_n = 1'b1;
    tick(5);

    // 1: single valid frame
    expect_ev(EV_EN, 8'h1C, 0, 170);
    send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
    drain("t1_drain");

    // 2: back-to-back frames
    expect_ev(EV_EN, 8'hF0, 0, 170);
    send_frame(8'hF0, 1'b0, 1'b1, 11, -1);
    expect_ev(EV_EN, 8'h1C, 0, 170);
    send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
    drain("t2_drain");

    // 3: parity error keeps previous byte
    expect_ev(EV_PE, 8'h00, 0, 170);
    send_frame(8'h1C, 1'b1, 1'b1, 11, -1);
    drain("t3_drain");
    check_val("t3_hold", o_byte, 8'h1C);

    // 4: bad stop bit
    expect_ev(EV_FE, 8'h00, 0, 170);
    send_frame(8'h32, 1'b0, 1'b0, 11, -1);
    drain("t4_drain");

    // 5: short clock glitches in IDLE and mid-frame are ignored
    ps2_clk = 1'b0;
    tick(2);
    ps2_clk = 1'b1;
    tick(HALF);
    expect_ev(EV_EN, 8'h32, 0, 170);
    send_frame(8'h32, 1'b0, 1'b1, 11, 3);
    drain("t5_drain");
    check_val("t5_byte", o_byte, 8'h32);

    // 6: truncated frame times out, then a clean frame follows
    expect_ev(EV_FE, 8'h00, 5000 * CLK_NS, 5012 * CLK_NS);
    send_frame(8'h1C, 1'b0, 1'b1, 5, -1);
    tick(6000);
    drain("t6_drain");
    expect_ev(EV_EN, 8'h1C, 0, 170);
    send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
    drain("t6_next");

    // 7: reset mid-frame clears outputs immediately
    send_frame(8'hA5, 1'b0, 1'b1, 5, -1);
    rst_n = 1'b0;
    #1;
    check_val("t7_byte", o_byte, 8'h00);
    check_val("t7_strobes", {5'd0, o_byte_en, o_parity_err, o_frame_err}, 8'h00);
    model_byte = 8'h00;
    tick(3);
    rst_n = 1'b1;
    tick(5);
    expect_ev(EV_EN, 8'h55, 0, 170);
    send_frame(8'h55, 1'b0, 1'b1, 11, -1);
    drain("t7_next");
    check_val("t7_final", o_byte, 8'h55);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
